vga_frame_reader: RTL



---
 rtl/vga_frame_reader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA scan-out of a grayscale image held in the interpolation output memory.
// Define VGA_BORDER_EN to draw a 1-pixel white frame just outside the image window.
module vga_frame_reader #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RD_LAT   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dimensiones,
   input  logic [7:0]  pixel,
   output logic [18:0] DataAdr_VGA,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic        r_tick;
   logic        r_first;
   logic [9:0]  r_h;
   logic [9:0]  r_v;
   logic [7:0]  r_w;
   logic [7:0]  r_hgt;
   logic [18:0] r_row;
   logic [18:0] r_adr;

   logic [RD_LAT:0]   r_hs_sh;
   logic [RD_LAT:0]   r_vs_sh;
   logic [RD_LAT:0]   r_vis_sh;
   logic [RD_LAT-1:0] r_show_sh;
   logic [RD_LAT-1:0] r_bdr_sh;
   logic [7:0]        r_pix;

   logic        w_h_end;
   logic        w_v_end;
   logic        w_latch;
   logic [9:0]  w_h_nxt;
   logic [9:0]  w_v_nxt;
   logic [7:0]  w_w_nxt;
   logic [7:0]  w_hgt_nxt;
   logic [9:0]  w_wz;
   logic [9:0]  w_hz;
   logic [18:0] w_row_nxt;
   logic        w_win_nxt;
   logic [18:0] w_adr_nxt;
   logic        w_hs;
   logic        w_vs;
   logic        w_vis;
   logic        w_show;
   logic        w_bdr;

   // Next counter position, used so the address lands together with the counters.
   assign w_h_end   = (r_h == H_LAST);
   assign w_v_end   = (r_v == V_LAST);
   assign w_h_nxt   = w_h_end ? 10'd0 : r_h + 10'd1;
   assign w_v_nxt   = !w_h_end ? r_v : (w_v_end ? 10'd0 : r_v + 10'd1);
   assign w_latch   = r_tick && ((w_h_end && w_v_end) || r_first);
   assign w_w_nxt   = w_latch ? dimensiones[15:8] : r_w;
   assign w_hgt_nxt = w_latch ? dimensiones[7:0]  : r_hgt;
   assign w_wz      = {2'b00, r_w};
   assign w_hz      = {2'b00, r_hgt};

   always_comb begin
      w_row_nxt = r_row;
      if (w_h_end) begin
         if (w_v_end) begin
            w_row_nxt = 19'd0;
         end else if (r_v < w_hz) begin
            w_row_nxt = r_row + {11'd0, r_w};
         end
      end
   end

   assign w_win_nxt = (w_h_nxt < {2'b00, w_w_nxt}) && (w_v_nxt < {2'b00, w_hgt_nxt});
   assign w_adr_nxt = w_win_nxt ? (w_row_nxt + {9'd0, w_h_nxt}) : 19'd0;

   assign w_hs   = !((r_h >= HS_BEG) && (r_h < HS_END));
   assign w_vs   = !((r_v >= VS_BEG) && (r_v < VS_END));
   assign w_vis  = (r_h < H_VIS) && (r_v < V_VIS);
   assign w_show = w_vis && (r_h < w_wz) && (r_v < w_hz);

`ifdef VGA_BORDER_EN
   assign w_bdr = (r_w != 8'd0) && (r_hgt != 8'd0) && w_vis &&
                  (((r_h == w_wz) && (r_v <= w_hz)) || ((r_v == w_hz) && (r_h <= w_wz)));
`else
   assign w_bdr = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick  <= 1'b0;
         r_first <= 1'b1;
         r_h     <= 10'd0;
         r_v     <= 10'd0;
         r_w     <= 8'd0;
         r_hgt   <= 8'd0;
         r_row   <= 19'd0;
         r_adr   <= 19'd0;
      end else begin
         r_tick <= !r_tick;
         if (r_tick) begin
            r_first <= 1'b0;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
            r_w     <= w_w_nxt;
            r_hgt   <= w_hgt_nxt;
            r_row   <= w_row_nxt;
            r_adr   <= w_adr_nxt;
         end
      end
   end

   // Output alignment: flags ride a per-clk shift matching the memory read latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hs_sh   <= '1;
         r_vs_sh   <= '1;
         r_vis_sh  <= '0;
         r_show_sh <= '0;
         r_bdr_sh  <= '0;
         r_pix     <= 8'd0;
      end else begin
         r_hs_sh[0]   <= w_hs;
         r_vs_sh[0]   <= w_vs;
         r_vis_sh[0]  <= w_vis;
         r_show_sh[0] <= w_show;
         r_bdr_sh[0]  <= w_bdr;
         for (int i = 1; i <= RD_LAT; i++) begin
            r_hs_sh[i]  <= r_hs_sh[i-1];
            r_vs_sh[i]  <= r_vs_sh[i-1];
            r_vis_sh[i] <= r_vis_sh[i-1];
         end
         for (int i = 1; i < RD_LAT; i++) begin
            r_show_sh[i] <= r_show_sh[i-1];
            r_bdr_sh[i]  <= r_bdr_sh[i-1];
         end
         if (r_show_sh[RD_LAT-1]) begin
            r_pix <= pixel;
         end else if (r_bdr_sh[RD_LAT-1]) begin
            r_pix <= 8'hFF;
         end else begin
            r_pix <= 8'd0;
         end
      end
   end

   assign DataAdr_VGA = r_adr;
   assign hsync       = r_hs_sh[RD_LAT];
   assign vsync       = r_vs_sh[RD_LAT];
   assign blank_n     = r_vis_sh[RD_LAT];
   assign vga_r       = r_pix;
   assign vga_g       = r_pix;
   assign vga_b       = r_pix;
   assign frame_start = r_tick && (r_h == 10'd0) && (r_v == 10'd0);

endmodule
